// File: rtl/acq_sweep_sequencer_if.sv
// Purpose : control/status bundle between the register block (master) and the
//           acquisition sweep sequencer (slave).
// Latency : wires only; no storage.
// Backpressure: none; start/abort/trigger are level-sampled by the sequencer.
// Ports   : start, abort, trigger, count_max, n_sweeps, decim (only when
//           ACQ_SEQ_DECIM_EN is defined) -> sequencer;
//           address, wen, first, armed, busy, done, sweeps_done <- sequencer.
interface acq_sweep_sequencer_if #(
    parameter int COUNT_WIDTH = 13,
    parameter int SWEEP_WIDTH = 16
`ifdef ACQ_SEQ_DECIM_EN
    ,
    parameter int DECIM_WIDTH = 8
`endif
);
    logic                   start;
    logic                   abort;
    logic                   trigger;
    logic [COUNT_WIDTH-1:0] count_max;
    logic [SWEEP_WIDTH-1:0] n_sweeps;
`ifdef ACQ_SEQ_DECIM_EN
    logic [DECIM_WIDTH-1:0] decim;
`endif
    logic [COUNT_WIDTH+1:0] address;
    logic                   wen;
    logic                   first;
    logic                   armed;
    logic                   busy;
    logic                   done;
    logic [SWEEP_WIDTH-1:0] sweeps_done;

    modport master (
`ifdef ACQ_SEQ_DECIM_EN
        output decim,
`endif
        output start, abort, trigger, count_max, n_sweeps,
        input  address, wen, first, armed, busy, done, sweeps_done
    );

    modport slave (
`ifdef ACQ_SEQ_DECIM_EN
        input  decim,
`endif
        input  start, abort, trigger, count_max, n_sweeps,
        output address, wen, first, armed, busy, done, sweeps_done
    );
endinterface

// File: rtl/acq_sweep_sequencer.sv
// Purpose : arm on start, wait for trigger, sweep word addresses 0..count_max
//           (as byte addresses) with write enable, repeated for n_sweeps sweeps.
// Latency : all outputs registered; first sample is visible the cycle after the
//           trigger is sampled.
// Backpressure: none; abort wins over everything, start is honoured in IDLE only.
// Optional : define ACQ_SEQ_DECIM_EN to add the decim input and a prescaler that
//            holds each address for decim+1 cycles, sampling on the last one.
// Ports   : clk, resetn (async active-low), sif (slave side of
//           acq_sweep_sequencer_if: control/config in, address/status out).
module acq_sweep_sequencer #(
    parameter int COUNT_WIDTH = 13,
    parameter int SWEEP_WIDTH = 16
`ifdef ACQ_SEQ_DECIM_EN
    ,
    parameter int DECIM_WIDTH = 8
`endif
) (
    input  logic                  clk,
    input  logic                  resetn,
    acq_sweep_sequencer_if.slave  sif
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_SWEEP = 2'd2
    } state_t;

    state_t                 state_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   wen_q;
    logic                   first_q;
    logic                   armed_q;
    logic                   busy_q;
    logic                   done_q;
    logic [SWEEP_WIDTH-1:0] sweeps_q;
    logic [COUNT_WIDTH-1:0] cmax_q;
    logic [SWEEP_WIDTH-1:0] nsw_q;

    logic                   sample;
    logic                   last_sample;
    logic                   final_sweep;
    logic [SWEEP_WIDTH-1:0] sweeps_inc;
    logic                   wen_on_entry;

`ifdef ACQ_SEQ_DECIM_EN
    logic [DECIM_WIDTH-1:0] decim_q;
    logic [DECIM_WIDTH-1:0] presc_q;
    logic [DECIM_WIDTH-1:0] presc_nxt;

    assign presc_nxt    = presc_q + 1'b1;
    assign sample       = (state_q == S_SWEEP) && (presc_q == decim_q);
    // A fresh address starts with prescaler 0, so it is sampled at once only
    // when no decimation is configured.
    assign wen_on_entry = (decim_q == '0);
`else
    assign sample       = (state_q == S_SWEEP);
    assign wen_on_entry = 1'b1;
`endif

    assign last_sample = sample && (count_q == cmax_q);
    // Widened by one bit so the compare cannot alias through a wrap.
    assign final_sweep = (({1'b0, sweeps_q} + 1'b1) == {1'b0, nsw_q});
    assign sweeps_inc  = (&sweeps_q) ? sweeps_q : sweeps_q + 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            wen_q    <= 1'b0;
            first_q  <= 1'b0;
            armed_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sweeps_q <= '0;
            cmax_q   <= '0;
            nsw_q    <= '0;
`ifdef ACQ_SEQ_DECIM_EN
            decim_q  <= '0;
            presc_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (sif.abort) begin
                // sweeps_done is left alone so software can see how far it got.
                state_q <= S_IDLE;
                count_q <= '0;
                wen_q   <= 1'b0;
                first_q <= 1'b0;
                armed_q <= 1'b0;
                busy_q  <= 1'b0;
`ifdef ACQ_SEQ_DECIM_EN
                presc_q <= '0;
`endif
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (sif.start) begin
                            cmax_q   <= sif.count_max;
                            nsw_q    <= (sif.n_sweeps == '0) ? SWEEP_WIDTH'(1) : sif.n_sweeps;
`ifdef ACQ_SEQ_DECIM_EN
                            decim_q  <= sif.decim;
`endif
                            sweeps_q <= '0;
                            first_q  <= 1'b1;
                            armed_q  <= 1'b1;
                            busy_q   <= 1'b1;
                            state_q  <= S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        if (sif.trigger) begin
                            state_q <= S_SWEEP;
                            count_q <= '0;
                            armed_q <= 1'b0;
                            wen_q   <= wen_on_entry;
`ifdef ACQ_SEQ_DECIM_EN
                            presc_q <= '0;
`endif
                        end
                    end
                    S_SWEEP: begin
                        if (last_sample) begin
                            sweeps_q <= sweeps_inc;
                            count_q  <= '0;
                            wen_q    <= 1'b0;
                            first_q  <= 1'b0;
`ifdef ACQ_SEQ_DECIM_EN
                            presc_q  <= '0;
`endif
                            if (final_sweep) begin
                                state_q <= S_IDLE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= S_ARMED;
                                armed_q <= 1'b1;
                            end
                        end else if (sample) begin
                            count_q <= count_q + 1'b1;
                            wen_q   <= wen_on_entry;
`ifdef ACQ_SEQ_DECIM_EN
                            presc_q <= '0;
`endif
                        end
`ifdef ACQ_SEQ_DECIM_EN
                        else begin
                            // Holding the current address; sample on its last cycle.
                            presc_q <= presc_nxt;
                            wen_q   <= (presc_nxt == decim_q);
                        end
`endif
                    end
                    default: begin
                        state_q <= S_IDLE;
                        wen_q   <= 1'b0;
                        armed_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sif.address     = {count_q, 2'b00};
    assign sif.wen         = wen_q;
    assign sif.first       = first_q;
    assign sif.armed       = armed_q;
    assign sif.busy        = busy_q;
    assign sif.done        = done_q;
    assign sif.sweeps_done = sweeps_q;

endmodule

// File: doc/acq_sweep_sequencer.md
Name: acq_sweep_sequencer

Overview:
- Sequences a BRAM acquisition or playback address sweep.
- Arm on a start request, wait for a trigger, sweep word addresses 0..count_max as byte addresses with write enable, and repeat for N triggered sweeps.
- Produces the address, write-enable and first-sweep flag that feed an averaging accumulator/BRAM port.
- Sits between the control registers (start/abort/config) and the memory datapath.

Parameters:
- COUNT_WIDTH, 13, width of the word counter; address output is COUNT_WIDTH+2 bits.
- SWEEP_WIDTH, 16, width of the sweep-count configuration and status.
- DECIM_WIDTH, 8, width of the decimation factor (used only with ACQ_SEQ_DECIM_EN).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  request a new acquisition; sampled in IDLE only.
- abort  input  1  stop immediately; return to IDLE.
- trigger  input  1  level-sampled trigger; starts a sweep when ARMED.
- count_max  input  COUNT_WIDTH  last word index of a sweep; latched on start.
- n_sweeps  input  SWEEP_WIDTH  number of sweeps; latched on start; 0 treated as 1.
- decim  input  DECIM_WIDTH  cycles-per-sample minus 1; latched on start (ACQ_SEQ_DECIM_EN only).
- address  output  COUNT_WIDTH+2  byte address = {count, 2'b00}.
- wen  output  1  memory write/sample enable.
- first  output  1  high during the first sweep (accumulator overwrite rather than add).
- armed  output  1  high in ARMED.
- busy  output  1  high in ARMED or SWEEP.
- done  output  1  one-cycle pulse when the last sweep completes.
- sweeps_done  output  SWEEP_WIDTH  completed sweeps in the current or last acquisition.

Behaviour:
- Reset (resetn=0, async):
  - state=IDLE; count=0, so address=0.
  - wen=0, first=0, armed=0, busy=0, done=0, sweeps_done=0.
  - Latched configuration registers cleared to 0.
- All outputs are registered.
- IDLE:
  - When start=1, latch count_max and n_sweeps (0 becomes 1) and decim; clear sweeps_done; set first=1; go to ARMED next cycle.
  - done is 0 except for the single post-sweep pulse cycle.
- ARMED:
  - When trigger=1 is sampled at edge k: state=SWEEP, count=0 and wen=1 are all visible after edge k, so the sweep starts with 1-cycle latency.
  - A trigger held high across sweeps immediately retriggers.
- SWEEP:
  - count increments by 1 per sample, and wen=1 on every sample cycle.
  - When count==count_max_reg on a sample cycle, that sample is the last: wen=1 for it and sweeps_done increments.
  - Next state after the last sample:
    - If sweeps_done+1 == n_sweeps_reg: go to IDLE, pulse done for 1 cycle, wen=0, count=0.
    - Else: go to ARMED, count=0, wen=0, first=0.
- count_max_reg=0 gives a 1-sample sweep (address 0 only).
- sweeps_done saturates at all-ones and never wraps; n_sweeps_reg bounds it.
- abort=1 in any state: next cycle state=IDLE, wen=0, count=0, done=0. sweeps_done holds its value; first=0.
- Priorities:
  - abort beats start and trigger.
  - start outside IDLE is ignored.
  - Configuration inputs changing mid-acquisition have no effect until the next start.
- start and the done pulse in the same cycle: start is ignored, because the state is not IDLE until the following cycle.

Optional Feature:
- Macro: ACQ_SEQ_DECIM_EN.
- Defined:
  - decim port present; a prescaler counts 0..decim_reg within SWEEP.
  - A sample cycle is one where prescaler==decim_reg. wen=1 only on those cycles, and count advances only after them.
  - The prescaler resets to 0 on sweep entry and on abort.
  - decim=0 behaves exactly like the undefined case.
- Undefined: no decim port or prescaler; every SWEEP cycle is a sample cycle.

Test Plan:
- Reset then start, count_max=3, n_sweeps=1, trigger pulse -> wen high for 4 cycles, addresses 0,4,8,12, first=1, done pulse 1 cycle after address 12, sweeps_done=1.
- count_max=1, n_sweeps=3, trigger pulsed 3 times with gaps -> 3 sweeps of 0,4; first=1 only in sweep 1; armed between sweeps; done after the third sweep; sweeps_done=3.
- n_sweeps=0, count_max=0 -> single sweep of one sample at address 0, then done.
- Abort during SWEEP at address 8 -> next cycle IDLE, wen=0, address 0, no done pulse; a new start works normally.
- Assert resetn=0 asynchronously mid-sweep -> outputs go to reset values without waiting for a clock edge; start ignored while busy; count_max change mid-sweep has no effect.
- With ACQ_SEQ_DECIM_EN, decim=2, count_max=2 -> wen on every third cycle, addresses 0,4,8 each held 3 cycles, then done.
